// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch driver.
//   op_e     : command opcode carried on cmd_op
//   status_e : response code carried on rsp_status
//   state_e  : driver FSM states
package sr_latch_drv_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        OP_HOLD    = 2'b00,
        OP_SET     = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK             = 2'b00,
        ST_WRONG_VALUE    = 2'b01,
        ST_NOT_COMPLEMENT = 2'b10,
        ST_ILLEGAL_CMD    = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PULSE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_RESP   = 3'd4
    } state_e;

endpackage : sr_latch_drv_pkg

// File: rtl/sr_latch_driver_if.sv
// Command/response handshake bundle between a controller and the latch driver.
//   cmd_valid/cmd_ready/cmd_op          : command channel (controller -> driver)
//   rsp_valid/rsp_ready/rsp_status/rsp_q : response channel (driver -> controller)
//   master : controller side, slave : driver side
interface sr_latch_driver_if;
    import sr_latch_drv_pkg::*;

    logic    cmd_valid;
    logic    cmd_ready;
    op_e     cmd_op;
    logic    rsp_valid;
    logic    rsp_ready;
    status_e rsp_status;
    logic    rsp_q;

    modport master (
        output cmd_valid, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_status, rsp_q
    );

    modport slave (
        input  cmd_valid, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_status, rsp_q
    );

endinterface : sr_latch_driver_if

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for asynchronous level inputs, synchronous reset to 0.
//   clk, rst : clock and synchronous active-high reset
//   d_i      : asynchronous input bits
//   q_o      : synchronized copy, SYNC_STAGES cycles late
module sync_2ff
    import sr_latch_drv_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q;

    // Shift chain; stage 0 is the metastability-catching flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule : sync_2ff

// File: rtl/sr_latch_driver.sv
// Clocked initiator for an asynchronous active-low SR latch: pulses s_n or r_n,
// waits for the latch and synchronizer to settle, reads q/q_not back and reports.
//   clk, rst     : clock and synchronous active-high reset
//   bus          : command/response handshake (slave side)
//   s_n, r_n     : active-low set/reset drives to the latch
//   q_in,q_not_in: latch outputs, asynchronous to clk
//   busy         : high whenever the FSM is not idle
module sr_latch_driver
    import sr_latch_drv_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    sr_latch_driver_if.slave bus,
    output logic             s_n,
    output logic             r_n,
    input  logic             q_in,
    input  logic             q_not_in,
    output logic             busy
);

    localparam int unsigned SETTLE_TOTAL = SETTLE_CYCLES + SYNC_STAGES;
    localparam int unsigned CNT_MAX      = (PULSE_CYCLES > SETTLE_TOTAL) ? PULSE_CYCLES : SETTLE_TOTAL;
    localparam int unsigned CNT_W        = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    status_e          rsp_status_q, rsp_status_d;
    logic             rsp_q_q, rsp_q_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             s_n_q, s_n_d;
    logic             r_n_q, r_n_d;
    logic             busy_q, busy_d;

    logic [1:0]       sync_out;
    logic             sync_q;
    logic             sync_q_not;

    // Raw latch outputs are only ever seen through the synchronizer.
    sync_2ff #(
        .WIDTH (2)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({q_in, q_not_in}),
        .q_o (sync_out)
    );

    assign sync_q     = sync_out[1];
    assign sync_q_not = sync_out[0];

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= OP_HOLD;
            rsp_status_q <= ST_OK;
            rsp_q_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            s_n_q        <= 1'b1;
            r_n_q        <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            rsp_status_q <= rsp_status_d;
            rsp_q_q      <= rsp_q_d;
            rsp_valid_q  <= rsp_valid_d;
            s_n_q        <= s_n_d;
            r_n_q        <= r_n_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic; registered outputs are derived from the next state so
    // they line up exactly with the state they belong to.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        rsp_status_d = rsp_status_q;
        rsp_q_d      = rsp_q_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d = bus.cmd_op;
                    unique case (bus.cmd_op)
                        OP_SET, OP_CLEAR: begin
                            state_d = S_PULSE;
                            cnt_d   = CNT_W'(PULSE_CYCLES - 1);
                        end
                        OP_HOLD: begin
                            state_d = S_SETTLE;
                            cnt_d   = CNT_W'(SETTLE_TOTAL - 1);
                        end
                        OP_ILLEGAL: begin
                            state_d      = S_RESP;
                            rsp_status_d = ST_ILLEGAL_CMD;
                            rsp_q_d      = sync_q;
                        end
                    endcase
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_TOTAL - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CHECK: begin
                // Complementarity failure outranks a wrong value; hold checks only that.
                state_d = S_RESP;
                rsp_q_d = sync_q;
                if (sync_q == sync_q_not) begin
                    rsp_status_d = ST_NOT_COMPLEMENT;
                end else if ((op_q == OP_SET && !sync_q) || (op_q == OP_CLEAR && sync_q)) begin
                    rsp_status_d = ST_WRONG_VALUE;
                end else begin
                    rsp_status_d = ST_OK;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // op_d is a single value, so at most one drive can be low.
        s_n_d       = !((state_d == S_PULSE) && (op_d == OP_SET));
        r_n_d       = !((state_d == S_PULSE) && (op_d == OP_CLEAR));
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    assign bus.cmd_ready  = (state_q == S_IDLE) && !rst;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.rsp_q      = rsp_q_q;
    assign s_n            = s_n_q;
    assign r_n            = r_n_q;
    assign busy           = busy_q;

endmodule : sr_latch_driver

// File: tb/tb_sr_latch_driver.sv
module tb_sr_latch_driver;
    import sr_latch_drv_pkg::*;

    typedef struct {
        status_e st;
        logic    q;
        int      lat;
    } exp_t;

    logic clk;
    logic rst;
    logic s_n, r_n, busy;
    logic q_in, q_not_in;

    sr_latch_driver_if bus ();

    sr_latch_driver #(
        .PULSE_CYCLES  (4),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .s_n      (s_n),
        .r_n      (r_n),
        .q_in     (q_in),
        .q_not_in (q_not_in),
        .busy     (busy)
    );

    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    exp_t sb[$];

    // Behavioural NAND SR latch with optional stuck-at overrides.
    logic lat_q = 1'b0;
    logic model_q, model_qn;
    logic frc_en = 1'b0;
    logic frc_q  = 1'b0;
    logic frc_qn = 1'b0;

    always @(negedge s_n) lat_q = 1'b1;
    always @(negedge r_n) lat_q = 1'b0;
    assign model_q  = !s_n ? 1'b1 : (!r_n ? 1'b0 : lat_q);
    assign model_qn = !r_n ? 1'b1 : (!s_n ? 1'b0 : !lat_q);
    assign q_in     = frc_en ? frc_q  : model_q;
    assign q_not_in = frc_en ? frc_qn : model_qn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (s_n === 1'b0 && r_n === 1'b0) begin
                failures++;
                $display("FAIL drive_overlap s_n=%b r_n=%b required not both 0", s_n, r_n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and returns when the response appears (or budget expires).
    task automatic issue(input op_e op, output int lat, output int s_lo, output int s_first,
                         output int r_lo, output bit timeout);
        int n = 0;
        while (!bus.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        tick();
        bus.cmd_valid = 1'b0;
        lat = 1; s_lo = 0; s_first = 0; r_lo = 0;
        while (!bus.rsp_valid && lat < 100) begin
            if (!s_n) begin
                s_lo++;
                if (s_first == 0) s_first = lat;
            end
            if (!r_n) r_lo++;
            tick();
            lat++;
        end
        timeout = !bus.rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        mon_en = 1'b1;
        checks++;
        if (s_n !== 1'b1 || r_n !== 1'b1) begin
            failures++; $display("FAIL reset_drives got s_n=%b r_n=%b required 1 1", s_n, r_n);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_status !== ST_OK || bus.rsp_q !== 1'b0) begin
            failures++; $display("FAIL reset_rsp got v=%b st=%0d q=%b required 0 0 0",
                                 bus.rsp_valid, bus.rsp_status, bus.rsp_q);
        end
        checks++;
        if (busy !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got busy=%b rdy=%b required 0 0", busy, bus.cmd_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready got %b required 1", bus.cmd_ready);
        end
    endtask

    task automatic test_set();
        int lat, s_lo, s_first, r_lo; bit to; exp_t e;
        sb.push_back('{ST_OK, 1'b1, 10});
        issue(OP_SET, lat, s_lo, s_first, r_lo, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== e.lat) begin
            failures++; $display("FAIL set_latency got %0d (timeout=%0b) required %0d", lat, to, e.lat);
        end
        checks++;
        if (s_lo !== 4 || s_first !== 1 || r_lo !== 0) begin
            failures++; $display("FAIL set_pulse got s_lo=%0d first=%0d r_lo=%0d required 4 1 0",
                                 s_lo, s_first, r_lo);
        end
        checks++;
        if (bus.rsp_status !== e.st || bus.rsp_q !== e.q) begin
            failures++; $display("FAIL set_rsp got st=%0d q=%b required st=%0d q=%b",
                                 bus.rsp_status, bus.rsp_q, e.st, e.q);
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL set_release got v=%b rdy=%b required 0 1", bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_clear_backpressure();
        int lat, s_lo, s_first, r_lo; bit to; exp_t e;
        bus.rsp_ready = 1'b0;
        sb.push_back('{ST_OK, 1'b0, 10});
        issue(OP_CLEAR, lat, s_lo, s_first, r_lo, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== e.lat) begin
            failures++; $display("FAIL clear_latency got %0d (timeout=%0b) required %0d", lat, to, e.lat);
        end
        checks++;
        if (r_lo !== 4 || s_lo !== 0) begin
            failures++; $display("FAIL clear_pulse got r_lo=%0d s_lo=%0d required 4 0", r_lo, s_lo);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== e.st || bus.rsp_q !== e.q || bus.cmd_ready !== 1'b0) begin
                failures++; $display("FAIL clear_hold[%0d] got v=%b st=%0d q=%b rdy=%b required 1 %0d %b 0",
                                     i, bus.rsp_valid, bus.rsp_status, bus.rsp_q, bus.cmd_ready, e.st, e.q);
            end
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL clear_release got v=%b rdy=%b required 0 1", bus.rsp_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_stuck_low();
        int lat, s_lo, s_first, r_lo; bit to; exp_t e;
        frc_en = 1'b1; frc_q = 1'b0; frc_qn = 1'b1;
        tick(); tick(); tick();
        sb.push_back('{ST_WRONG_VALUE, 1'b0, 10});
        issue(OP_SET, lat, s_lo, s_first, r_lo, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== e.lat || bus.rsp_status !== e.st || bus.rsp_q !== e.q) begin
            failures++; $display("FAIL stuck_rsp got lat=%0d st=%0d q=%b required %0d %0d %b",
                                 lat, bus.rsp_status, bus.rsp_q, e.lat, e.st, e.q);
        end
        tick();
    endtask

    task automatic test_hold_not_complement();
        int lat, s_lo, s_first, r_lo; bit to; exp_t e;
        frc_en = 1'b1; frc_q = 1'b1; frc_qn = 1'b1;
        tick(); tick(); tick();
        sb.push_back('{ST_NOT_COMPLEMENT, 1'b1, 6});
        issue(OP_HOLD, lat, s_lo, s_first, r_lo, to);
        e = sb.pop_front();
        checks++;
        if (s_lo !== 0 || r_lo !== 0) begin
            failures++; $display("FAIL hold_pulse got s_lo=%0d r_lo=%0d required 0 0", s_lo, r_lo);
        end
        checks++;
        if (to || lat !== e.lat || bus.rsp_status !== e.st || bus.rsp_q !== e.q) begin
            failures++; $display("FAIL hold_rsp got lat=%0d st=%0d q=%b required %0d %0d %b",
                                 lat, bus.rsp_status, bus.rsp_q, e.lat, e.st, e.q);
        end
        tick();
        frc_en = 1'b0;
    endtask

    task automatic test_illegal();
        int lat, s_lo, s_first, r_lo; bit to; exp_t e;
        tick(); tick(); tick();
        sb.push_back('{ST_ILLEGAL_CMD, model_q, 1});
        issue(OP_ILLEGAL, lat, s_lo, s_first, r_lo, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== e.lat || bus.rsp_status !== e.st || bus.rsp_q !== e.q) begin
            failures++; $display("FAIL illegal_rsp got lat=%0d st=%0d q=%b required %0d %0d %b",
                                 lat, bus.rsp_status, bus.rsp_q, e.lat, e.st, e.q);
        end
        checks++;
        if (s_n !== 1'b1 || r_n !== 1'b1) begin
            failures++; $display("FAIL illegal_drive got s_n=%b r_n=%b required 1 1", s_n, r_n);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, s_lo, s_first, r_lo; bit to; exp_t e;
        sb.push_back('{ST_OK, 1'b1, 10});
        issue(OP_SET, lat, s_lo, s_first, r_lo, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== e.lat || bus.rsp_status !== e.st || bus.rsp_q !== e.q || bus.cmd_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_first got lat=%0d st=%0d q=%b rdy=%b required %0d %0d %b 0",
                                 lat, bus.rsp_status, bus.rsp_q, bus.cmd_ready, e.lat, e.st, e.q);
        end
        tick();
        sb.push_back('{ST_OK, 1'b0, 10});
        issue(OP_CLEAR, lat, s_lo, s_first, r_lo, to);
        e = sb.pop_front();
        checks++;
        if (to || lat !== e.lat || bus.rsp_status !== e.st || bus.rsp_q !== e.q || r_lo !== 4) begin
            failures++; $display("FAIL b2b_second got lat=%0d st=%0d q=%b r_lo=%0d required %0d %0d %b 4",
                                 lat, bus.rsp_status, bus.rsp_q, r_lo, e.lat, e.st, e.q);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        bit seen_valid = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SET;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        checks++;
        if (s_n !== 1'b0) begin
            failures++; $display("FAIL abort_pulse_active got s_n=%b required 0", s_n);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (s_n !== 1'b1 || r_n !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL abort_edge got s_n=%b r_n=%b busy=%b v=%b required 1 1 0 0",
                                 s_n, r_n, busy, bus.rsp_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            failures++; $display("FAIL abort_ready got %b required 1", bus.cmd_ready);
        end
        for (int i = 0; i < 12; i++) begin
            if (bus.rsp_valid !== 1'b0 || s_n !== 1'b1) seen_valid = 1'b1;
            tick();
        end
        checks++;
        if (seen_valid) begin
            failures++; $display("FAIL abort_quiet got activity=1 required 0");
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_HOLD;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_set();
        test_clear_backpressure();
        test_stuck_low();
        test_hold_not_complement();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sr_latch_driver

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Clocked initiator that drives the two active-low control inputs of an asynchronous SR latch. It reads back the latch outputs to confirm each operation.
- Accepts set, clear, or hold commands over a valid/ready interface. It generates a fixed-width pulse, waits a settle interval, samples the synchronized q/q_not, and returns a status response.
- Sits between a test or control FSM and any latch variant in the logic-design projects.

Parameters:
PULSE_CYCLES, 4, cycles s_n or r_n is held low per set or clear; legal range 1 or more
SETTLE_CYCLES, 2, extra wait cycles after pulse release before sampling; legal range 0 or more

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  high when the block can accept a command
cmd_op  input  2  00 hold, 01 set (expect q=1), 10 clear (expect q=0), 11 illegal
s_n  output  1  active-low set drive to the latch
r_n  output  1  active-low reset drive to the latch
q_in  input  1  latch q, asynchronous to clk
q_not_in  input  1  latch q_not, asynchronous to clk
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer ready
rsp_status  output  2  00 OK, 01 WRONG_VALUE, 10 NOT_COMPLEMENT, 11 ILLEGAL_CMD
rsp_q  output  1  synchronized q sampled in CHECK
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clock edge) drives: s_n=1, r_n=1, cmd_ready=0 that cycle, rsp_valid=0, rsp_status=00, rsp_q=0, busy=0, state=IDLE, counters cleared, synchronizer flops cleared to 0.
  - Reset mid-operation aborts immediately. Any active pulse is released on that same edge.
- cmd_ready = (state==IDLE) && !rst. A command is accepted in cycle T when cmd_valid && cmd_ready. cmd_op is registered at T.
- States are IDLE, PULSE, SETTLE, CHECK, RESP.
  - IDLE:
    - op 01 or 10 goes to PULSE.
    - op 00 goes to SETTLE.
    - op 11 goes to RESP with status 11 and rsp_q = current synchronized q. rsp_valid is high at T+1.
  - PULSE: held for exactly PULSE_CYCLES cycles, T+1 through T+PULSE_CYCLES.
    - set drives s_n=0.
    - clear drives r_n=0.
    - The other drive stays 1.
  - SETTLE: held for SETTLE_CYCLES+2 cycles. The +2 covers the 2-flop synchronizer. Both drives are 1.
  - CHECK: lasts 1 cycle and registers rsp_q and rsp_status. Status priority:
    - If sync_q == sync_q_not, status is NOT_COMPLEMENT.
    - Else, for set or clear, if sync_q differs from the expected value, status is WRONG_VALUE.
    - Otherwise status is OK.
    - Hold only checks complementarity.
  - RESP: rsp_valid=1. rsp_status and rsp_q stay stable until rsp_valid && rsp_ready, then the block returns to IDLE on the next cycle.
- Latency for set or clear: rsp_valid first high at T+PULSE_CYCLES+SETTLE_CYCLES+4. With defaults this is T+10. Hold: T+SETTLE_CYCLES+4.
- If rsp_ready is already high when entering RESP, rsp_valid is high for one cycle, and cmd_ready returns on the following cycle. Back-to-back commands have a minimum gap of 1 IDLE cycle.
- Invariant: s_n and r_n are never both 0 in any cycle, including during reset and abort. Neither drive changes outside the PULSE state.
- Counter width is $clog2(max(PULSE_CYCLES, SETTLE_CYCLES+2)+1). Counters count down and load on state entry. There is no wrap: a counter reaching 0 forces the state transition.
- q_in and q_not_in pass only through the synchronizer. No FSM logic uses the raw inputs.

Decomposition:
- Package sr_latch_drv_pkg holds:
  - the op_e enum (HOLD, SET, CLEAR, ILLEGAL);
  - the status_e enum (OK, WRONG_VALUE, NOT_COMPLEMENT, ILLEGAL_CMD);
  - the state_e enum;
  - the localparam SYNC_STAGES = 2.
- Sub-module sync_2ff is a parameterized-width 2-flop synchronizer with synchronous reset. It is instantiated once with width 2 for {q_in, q_not_in}.

Test Plan:
1. Reset, then a set command at T with a behavioural NAND latch model attached:
   - s_n=0 during T+1..T+4, and r_n stays 1 throughout.
   - rsp_valid rises at T+10 with status 00 and rsp_q=1.
2. Clear command after scenario 1:
   - r_n=0 for 4 cycles.
   - Response has status 00 and rsp_q=0.
   - Hold rsp_ready=0 for 5 cycles: response fields stay stable, cmd_ready stays 0.
3. Set command with the model's q forced stuck at 0 and q_not at 1 -> status 01, rsp_q=0.
4. Hold command with q=1 and q_not=1 forced -> no pulse on either drive, status 10 at T+6.
5. cmd_op=11 -> no drive activity, rsp_valid at T+1 with status 11.
6. Assert rst at T+2 of a set pulse:
   - s_n=1 after that edge.
   - rsp_valid stays 0, state returns to IDLE.
   - cmd_ready is high in the first cycle after rst deasserts.
   - The s_n/r_n never-both-low assertion holds for the whole run.
